// File: rtl/sc_road_pkg.sv
// Shared road-pipeline definitions: spawner FSM states, density masks,
// counter widths and small arithmetic helpers.
package sc_road_pkg;

  localparam int COUNT_W = 8;
  localparam int GAP_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    GAP  = 2'd2
  } spawn_state_e;

  localparam logic [3:0] DENS_MASK_0 = 4'hF;
  localparam logic [3:0] DENS_MASK_1 = 4'h7;
  localparam logic [3:0] DENS_MASK_2 = 4'h3;
  localparam logic [3:0] DENS_MASK_3 = 4'h0;

  function automatic logic [3:0] density_mask(input logic [1:0] density);
    logic [3:0] m;
    case (density)
      2'd0:    m = DENS_MASK_0;
      2'd1:    m = DENS_MASK_1;
      2'd2:    m = DENS_MASK_2;
      2'd3:    m = DENS_MASK_3;
      default: m = DENS_MASK_0;
    endcase
    return m;
  endfunction

  // Widened to the counter before adding so GAPMIN+15 cannot wrap.
  function automatic logic [GAP_W-1:0] gap_value(input logic [3:0] gapmin,
                                                 input logic [3:0] rnd,
                                                 input logic [1:0] density);
    return GAP_W'(gapmin) + GAP_W'(rnd & density_mask(density));
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == {COUNT_W{1'b1}}) ? c : c + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/sc_obstacle_spawner_if.sv
// Game-step and row bus between the LFSR/timing logic, the obstacle spawner
// and the road matrix.
interface sc_obstacle_spawner_if #(
  parameter int DW = 8
);
  logic          SC_ObstacleSPAWNER_run_InLow;
  logic          SC_ObstacleSPAWNER_tick_In;
  logic [7:0]    SC_ObstacleSPAWNER_random_InBUS;
  logic [1:0]    SC_ObstacleSPAWNER_density_InBUS;
  logic [DW-1:0] SC_ObstacleSPAWNER_row_OutBUS;
  logic          SC_ObstacleSPAWNER_rowValid_Out;
  logic [7:0]    SC_ObstacleSPAWNER_count_OutBUS;

  modport master (
    output SC_ObstacleSPAWNER_run_InLow,
    output SC_ObstacleSPAWNER_tick_In,
    output SC_ObstacleSPAWNER_random_InBUS,
    output SC_ObstacleSPAWNER_density_InBUS,
    input  SC_ObstacleSPAWNER_row_OutBUS,
    input  SC_ObstacleSPAWNER_rowValid_Out,
    input  SC_ObstacleSPAWNER_count_OutBUS
  );

  modport slave (
    input  SC_ObstacleSPAWNER_run_InLow,
    input  SC_ObstacleSPAWNER_tick_In,
    input  SC_ObstacleSPAWNER_random_InBUS,
    input  SC_ObstacleSPAWNER_density_InBUS,
    output SC_ObstacleSPAWNER_row_OutBUS,
    output SC_ObstacleSPAWNER_rowValid_Out,
    output SC_ObstacleSPAWNER_count_OutBUS
  );
endinterface

// File: rtl/sc_gap_counter.sv
// Loadable down counter holding the number of empty rows still owed before
// the next obstacle; load wins over dec, and it stops at zero.
module sc_gap_counter
  import sc_road_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  // Next count: load, decrement or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sc_obstacle_spawner.sv
// Emits one road row per game tick with randomised, density-scaled obstacle
// spacing. Define SC_OBSTACLESPAWNER_DOUBLE_EN for optional two-lane rows.
module sc_obstacle_spawner
  import sc_road_pkg::*;
#(
  parameter int RegSPAWNER_DATAWIDTH = 8,
  parameter int RegSPAWNER_GAPMIN    = 2
) (
  input  logic                 SC_ObstacleSPAWNER_CLOCK_50,
  input  logic                 SC_ObstacleSPAWNER_RESET_InLow,
  sc_obstacle_spawner_if.slave bus
);

  localparam int DW       = RegSPAWNER_DATAWIDTH;
  localparam int LANEBITS = $clog2(RegSPAWNER_DATAWIDTH);

  spawn_state_e         state_q, state_d;
  logic [DW-1:0]        row_q, row_d;
  logic                 valid_q, valid_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic                 run_s;
  logic                 tick_s;
  logic                 gap_load_s;
  logic                 gap_dec_s;
  logic                 gap_zero_s;
  logic [GAP_W-1:0]     gap_val_s;
  logic [LANEBITS-1:0]  lane_s;
  logic [DW-1:0]        obst_row_s;
  logic                 unused_rnd_s;

  assign run_s        = ~bus.SC_ObstacleSPAWNER_run_InLow;
  assign tick_s       = bus.SC_ObstacleSPAWNER_tick_In;
  assign lane_s       = bus.SC_ObstacleSPAWNER_random_InBUS[LANEBITS-1:0];
  assign gap_val_s    = gap_value(4'(RegSPAWNER_GAPMIN),
                                  bus.SC_ObstacleSPAWNER_random_InBUS[6:3],
                                  bus.SC_ObstacleSPAWNER_density_InBUS);
  assign unused_rnd_s = ^bus.SC_ObstacleSPAWNER_random_InBUS;

`ifdef SC_OBSTACLESPAWNER_DOUBLE_EN
  // Opposite lane is half the road away; the lane index wraps naturally.
  logic [LANEBITS-1:0] lane2_s;
  assign lane2_s    = lane_s + LANEBITS'(DW / 2);
  assign obst_row_s = bus.SC_ObstacleSPAWNER_random_InBUS[7]
                      ? ((DW'(1) << lane_s) | (DW'(1) << lane2_s))
                      : (DW'(1) << lane_s);
`else
  assign obst_row_s = DW'(1) << lane_s;
`endif

  sc_gap_counter u_gap (
    .clk_i      (SC_ObstacleSPAWNER_CLOCK_50),
    .rst_ni     (SC_ObstacleSPAWNER_RESET_InLow),
    .load_i     (gap_load_s),
    .load_val_i (gap_val_s),
    .dec_i      (gap_dec_s),
    .zero_o     (gap_zero_s)
  );

  // Next state, row and count; leaving run beats any tick that cycle.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    gap_load_s = 1'b0;
    gap_dec_s  = 1'b0;
    if (!run_s) begin
      state_d = IDLE;
      row_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          row_d   = '0;
        end
        ARM: begin
          gap_load_s = 1'b1;
          state_d    = GAP;
          if (tick_s) begin
            valid_d = 1'b1;
            row_d   = '0;
          end else begin
            valid_d = 1'b0;
          end
        end
        GAP: begin
          if (tick_s) begin
            valid_d = 1'b1;
            if (gap_zero_s) begin
              row_d   = obst_row_s;
              count_d = sat_inc(count_q);
              state_d = ARM;
            end else begin
              row_d     = '0;
              gap_dec_s = 1'b1;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge SC_ObstacleSPAWNER_CLOCK_50 or negedge SC_ObstacleSPAWNER_RESET_InLow) begin
    if (!SC_ObstacleSPAWNER_RESET_InLow) begin
      state_q <= IDLE;
      row_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign bus.SC_ObstacleSPAWNER_row_OutBUS   = row_q;
  assign bus.SC_ObstacleSPAWNER_rowValid_Out = valid_q;
  assign bus.SC_ObstacleSPAWNER_count_OutBUS = count_q;

endmodule

// File: tb/tb_sc_obstacle_spawner.sv
// Directed bench for sc_obstacle_spawner (DATAWIDTH 8, GAPMIN 2); expected
// double-lane row follows SC_OBSTACLESPAWNER_DOUBLE_EN.
module tb_sc_obstacle_spawner;
  import sc_road_pkg::*;

`ifdef SC_OBSTACLESPAWNER_DOUBLE_EN
  localparam logic [7:0] EXP_81 = 8'h22;
`else
  localparam logic [7:0] EXP_81 = 8'h02;
`endif

  typedef struct {
    logic       run_n;
    logic       tick;
    logic [7:0] rnd;
    logic [1:0] dens;
    logic [7:0] exp_row;
    logic       exp_valid;
    logic [7:0] exp_count;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [7:0] exp_cnt;
  vec_t vecs [13];

  sc_obstacle_spawner_if #(.DW(8)) bus ();

  sc_obstacle_spawner #(
    .RegSPAWNER_DATAWIDTH (8),
    .RegSPAWNER_GAPMIN    (2)
  ) dut (
    .SC_ObstacleSPAWNER_CLOCK_50    (clk),
    .SC_ObstacleSPAWNER_RESET_InLow (rst_n),
    .bus                            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic run_n, input logic tick, input logic [7:0] rnd, input logic [1:0] dens);
    bus.SC_ObstacleSPAWNER_run_InLow    = run_n;
    bus.SC_ObstacleSPAWNER_tick_In      = tick;
    bus.SC_ObstacleSPAWNER_random_InBUS = rnd;
    bus.SC_ObstacleSPAWNER_density_InBUS = dens;
  endtask

  // Start from IDLE, tick every cycle until an obstacle appears.
  task automatic gap_run(input string name, input logic [1:0] dens, input logic [7:0] rnd,
                         input int exp_empty, input logic [7:0] exp_row);
    int empties;
    logic got;
    empties = 0;
    got = 1'b0;
    drive(1'b0, 1'b0, rnd, dens);
    step();
    step();
    for (int i = 0; i < 40 && !got; i++) begin
      drive(1'b0, 1'b1, rnd, dens);
      step();
      if (bus.SC_ObstacleSPAWNER_row_OutBUS != 8'h00) got = 1'b1;
      else empties++;
    end
    exp_cnt = sat_inc(exp_cnt);
    chk({name, "_empties"}, 32'(empties), 32'(exp_empty));
    chk({name, "_row"}, 32'(bus.SC_ObstacleSPAWNER_row_OutBUS), 32'(exp_row));
    chk({name, "_valid"}, 32'(bus.SC_ObstacleSPAWNER_rowValid_Out), 32'd1);
    chk({name, "_count"}, 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'(exp_cnt));
    drive(1'b1, 1'b0, rnd, dens);
    step();
  endtask

  initial begin
    int spawns;
    total = 0;
    bad = 0;
    exp_cnt = 8'h00;
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 2'd0);

    //            run tick rnd    dens row    vld   cnt
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b1, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 2'd0, 8'h00, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h01, 1'b1, 8'h01};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b1, 8'h01};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b1, 8'h01};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 2'd0, 8'h00, 1'b1, 8'h01};
    vecs[10] = '{1'b0, 1'b1, 8'h81, 2'd0, EXP_81, 1'b1, 8'h02};
    vecs[11] = '{1'b0, 1'b0, 8'h81, 2'd0, EXP_81, 1'b0, 8'h02};
    vecs[12] = '{1'b1, 1'b1, 8'h81, 2'd0, 8'h00, 1'b0, 8'h02};

    step();
    step();
    chk("reset_row", 32'(bus.SC_ObstacleSPAWNER_row_OutBUS), 32'h0);
    chk("reset_count", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].run_n, vecs[i].tick, vecs[i].rnd, vecs[i].dens);
      step();
      chk($sformatf("vec%0d_row", i), 32'(bus.SC_ObstacleSPAWNER_row_OutBUS), 32'(vecs[i].exp_row));
      chk($sformatf("vec%0d_valid", i), 32'(bus.SC_ObstacleSPAWNER_rowValid_Out), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'(vecs[i].exp_count));
    end
    chk("stop_state", 32'(dut.state_q), 32'(IDLE));
    exp_cnt = 8'h02;

    gap_run("dens0", 2'd0, 8'h7D, 17, 8'h20);
    gap_run("dens3", 2'd3, 8'h7D, 2, 8'h20);

    // Run stop together with a tick while in GAP.
    drive(1'b0, 1'b0, 8'h00, 2'd0);
    step();
    step();
    drive(1'b0, 1'b1, 8'h00, 2'd0);
    step();
    drive(1'b1, 1'b1, 8'h00, 2'd0);
    step();
    chk("runstop_valid", 32'(bus.SC_ObstacleSPAWNER_rowValid_Out), 32'd0);
    chk("runstop_row", 32'(bus.SC_ObstacleSPAWNER_row_OutBUS), 32'h0);
    chk("runstop_count", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'(exp_cnt));
    chk("runstop_state", 32'(dut.state_q), 32'(IDLE));

    // Asynchronous reset mid-gap, just after a valid empty row.
    drive(1'b0, 1'b0, 8'h00, 2'd0);
    step();
    step();
    drive(1'b0, 1'b1, 8'h00, 2'd0);
    step();
    chk("premid_valid", 32'(bus.SC_ObstacleSPAWNER_rowValid_Out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(bus.SC_ObstacleSPAWNER_rowValid_Out), 32'd0);
    chk("async_row", 32'(bus.SC_ObstacleSPAWNER_row_OutBUS), 32'h0);
    chk("async_count", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'h0);
    chk("async_state", 32'(dut.state_q), 32'(IDLE));
    drive(1'b0, 1'b0, 8'h00, 2'd3);
    rst_n = 1'b1;
    step();
    chk("restart_state", 32'(dut.state_q), 32'(ARM));

    // Saturation: back-to-back ticks, densest setting.
    spawns = 0;
    drive(1'b0, 1'b1, 8'h00, 2'd3);
    for (int c = 0; c < 1400 && spawns < 300; c++) begin
      step();
      if (bus.SC_ObstacleSPAWNER_rowValid_Out && (bus.SC_ObstacleSPAWNER_row_OutBUS != 8'h00)) begin
        spawns++;
        if (spawns == 254) chk("sat_254", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'hFE);
        if (spawns == 256) chk("sat_256", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'hFF);
      end
    end
    chk("sat_spawns", 32'(spawns), 32'd300);
    chk("sat_count", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'hFF);
    drive(1'b1, 1'b0, 8'h00, 2'd3);
    step();
    chk("sat_keep_after_stop", 32'(bus.SC_ObstacleSPAWNER_count_OutBUS), 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sc_obstacle_spawner.md
# sc_obstacle_spawner

Downstream consumer of the 8-bit LFSR random byte in the road pipeline. It samples the random bus on each game-step tick and emits one road row per tick into the top of the road matrix. A row is either empty or holds one obstacle lane (two lanes optionally). The spacing between obstacles is randomised and scaled by a density setting. It also keeps a saturating count of obstacles spawned.

## Interface
- RegSPAWNER_DATAWIDTH, default 8: lane count and row width; must be 4 or 8; LANEBITS = $clog2(RegSPAWNER_DATAWIDTH).
- RegSPAWNER_GAPMIN, default 2: minimum number of empty rows between obstacles, range 1..15.
- SC_ObstacleSPAWNER_CLOCK_50  in  1  system clock, all state on its rising edge.
- SC_ObstacleSPAWNER_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_ObstacleSPAWNER_run_InLow  in  1  level signal, active-low run enable (0 = running).
- SC_ObstacleSPAWNER_tick_In  in  1  one-cycle game-step pulse.
- SC_ObstacleSPAWNER_random_InBUS  in  8  random byte from the upstream LFSR.
- SC_ObstacleSPAWNER_density_InBUS  in  2  0 = sparse … 3 = densest.
- SC_ObstacleSPAWNER_row_OutBUS  out  RegSPAWNER_DATAWIDTH  registered row pattern, bit i = obstacle in lane i.
- SC_ObstacleSPAWNER_rowValid_Out  out  1  one-cycle pulse when a new row is presented.
- SC_ObstacleSPAWNER_count_OutBUS  out  8  saturating obstacle count.

## Operation
- FSM states:
  - IDLE: not running; ticks ignored; row_OutBUS forced to 0.
  - ARM: single cycle; loads the gap counter.
  - GAP: waits for ticks and emits rows.
- Transitions:
  - IDLE → ARM when run_InLow = 0.
  - ARM → GAP unconditionally.
  - GAP with tick and counter ≠ 0: emit empty row, decrement counter, stay in GAP.
  - GAP with tick and counter = 0: emit obstacle row, go to ARM.
  - Any state → IDLE when run_InLow = 1. This has priority over tick: no row and no valid pulse that cycle.
- Gap load in ARM:
  - gap = RegSPAWNER_GAPMIN + (random[6:3] & mask).
  - mask by density: 0 → 4'hF, 1 → 4'h7, 2 → 4'h3, 3 → 4'h0.
  - Counter is 5 bits; maximum value is GAPMIN+15.
- Tick during ARM: emits an empty row. The counter still loads the full gap, so that gap is one row longer.
- Obstacle row: one-hot at lane L = random[LANEBITS-1:0], using random sampled on the spawning tick.
- count_OutBUS: +1 per obstacle row, saturates at 255. Cleared only by reset; a run stop does not clear it.

## Timing
- Reset (asynchronous, active-low): state IDLE, counter 0, row_OutBUS = 0, rowValid_Out = 0, count_OutBUS = 0.
- Latency: tick and random are sampled at edge N. row_OutBUS and rowValid_Out update at edge N (visible in cycle N+1).
- rowValid_Out is high exactly one cycle. row_OutBUS holds until the next emitted row or until IDLE.
- After run_InLow falls at edge N, ARM occupies cycle N+1. The first obstacle comes on the (GAPMIN+masked+1)-th tick after ARM.
- Back-to-back ticks (every cycle) are legal; one row is emitted per tick.
- Reset asserted mid-gap: immediate return to IDLE with all outputs 0. After reset releases, the block restarts from ARM once run_InLow = 0.

## Configuration
- SC_OBSTACLESPAWNER_DOUBLE_EN defined:
  - When random[7] = 1, the obstacle row also sets lane (L + DATAWIDTH/2) mod DATAWIDTH.
  - count_OutBUS still increments by 1 per obstacle row.
- Undefined: obstacle rows are always one-hot, and random[7] is ignored.

## Structure
- Shared package sc_road_pkg holds:
  - the FSM state typedef (IDLE, ARM, GAP);
  - the density mask constants;
  - the count width (8) and gap counter width (5).
- One sub-module: sc_gap_counter, a loadable 5-bit down counter with load, dec and zero outputs, using the same clock and reset.

## Test plan
- Reset: assert RESET_InLow = 0 mid-operation → row 8'h00, valid 0, count 8'h00, state IDLE, asynchronously.
- Minimum gap, DATAWIDTH = 8, GAPMIN = 2: run_InLow = 0, random = 8'h00, density = 0, then three ticks → rows 8'h00, 8'h00, 8'h01; count = 1.
- Density masking: random = 8'h7D.
  - density 0 → 17 empty rows, then 8'h20.
  - density 3 → 2 empty rows, then 8'h20.
- Double lane: random = 8'h81 at the spawning tick → 8'h22 with SC_OBSTACLESPAWNER_DOUBLE_EN, 8'h02 without it.
- Run stop with simultaneous tick in GAP: run_InLow = 1 and tick in the same cycle → no valid pulse, row 8'h00, state IDLE, count unchanged.
- Saturation: random = 8'h00, density 3, ticks every cycle, 300 spawns → count_OutBUS holds at 8'hFF.
